// File: rtl/freq_ctrl_pkg.sv
// Shared definitions for the frequency control path: sweep FSM states,
// settle length and the default frequency index width.
package freq_ctrl_pkg;

    localparam int IDX_W_DEFAULT = 7;
    localparam int SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_DWELL,
        ST_STEP,
        ST_SETTLE
    } sweep_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Down-counting dwell timer: load sets the count, en counts down,
// done flags the last cycle of the dwell (terminal count of 1).
module dwell_timer #(
    parameter int DWELL_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] load_val,
    output logic               done
);

    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

    assign done = (cnt_q <= DWELL_W'(1));

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep scheduler driving the freq_sel step inputs: forwards manual
// triggers and runs single-pass or ping-pong sweeps with a per-step dwell.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no sweep; only manual triggers produce step pulses
// ST_SEEK   | first look at freq_num after start: at lo, or step toward it
// ST_DWELL  | holding the current index for the latched dwell count
// ST_STEP   | step pulse on the output this cycle; capture index as prev
// ST_SETTLE | wait for freq_sel to react, then judge stall / bounds
module freq_sweep_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int IDX_W   = IDX_W_DEFAULT,
    parameter int DWELL_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               freq_up_trigger_i,
    input  logic               freq_down_trigger_i,
    input  logic               sweep_start_i,
    input  logic               sweep_stop_i,
    input  logic [IDX_W-1:0]   sweep_lo_i,
    input  logic [IDX_W-1:0]   sweep_hi_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               sweep_mode_i,
    input  logic [IDX_W-1:0]   freq_num_i,
    output logic               step_up_o,
    output logic               step_down_o,
    output logic               sweep_busy_o,
    output logic               sweep_dir_o,
    output logic               sweep_err_o
);

    localparam logic [1:0] SETTLE_LOAD = 2'(SETTLE_CYCLES - 1);

    sweep_state_t       state_q, state_n;
    logic               dir_q, dir_n;
    logic               seek_q, seek_n;
    logic               mode_q, mode_n;
    logic [IDX_W-1:0]   lo_q, lo_n;
    logic [IDX_W-1:0]   hi_q, hi_n;
    logic [IDX_W-1:0]   prev_q, prev_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [1:0]         settle_q, settle_n;
    logic               up_n, down_n, err_n;
    logic               manual_up, manual_down;
    logic               seek_eval;
    logic               timer_load, timer_en, timer_done;

    dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (dwell_q),
        .done     (timer_done)
    );

    assign timer_en = (state_q == ST_DWELL);

    always_comb begin
        state_n     = state_q;
        dir_n       = dir_q;
        seek_n      = seek_q;
        mode_n      = mode_q;
        lo_n        = lo_q;
        hi_n        = hi_q;
        prev_n      = prev_q;
        dwell_n     = dwell_q;
        settle_n    = settle_q;
        up_n        = 1'b0;
        down_n      = 1'b0;
        err_n       = 1'b0;
        seek_eval   = 1'b0;
        timer_load  = 1'b0;
        manual_up   = freq_up_trigger_i & ~freq_down_trigger_i;
        manual_down = freq_down_trigger_i & ~freq_up_trigger_i;

        if (manual_up || manual_down) begin
            state_n = ST_IDLE;
            up_n    = manual_up;
            down_n  = manual_down;
        end else if (sweep_stop_i) begin
            state_n = ST_IDLE;
        end else if (sweep_start_i && (sweep_lo_i <= sweep_hi_i)) begin
            lo_n    = sweep_lo_i;
            hi_n    = sweep_hi_i;
            mode_n  = sweep_mode_i;
            dwell_n = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
            seek_n  = 1'b1;
            state_n = ST_SEEK;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_SEEK: seek_eval = 1'b1;
                ST_DWELL: begin
                    if (timer_done) begin
                        state_n = ST_STEP;
                        up_n    = dir_q;
                        down_n  = ~dir_q;
                    end
                end
                ST_STEP: begin
                    prev_n   = freq_num_i;
                    settle_n = SETTLE_LOAD;
                    state_n  = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q != 2'd0) begin
                        settle_n = settle_q - 2'd1;
                    end else if (freq_num_i == prev_q) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else if (seek_q) begin
                        seek_eval = 1'b1;
                    end else if (dir_q && freq_num_i == hi_q) begin
                        if (!mode_q) begin
                            state_n = ST_IDLE;
                        end else begin
                            dir_n      = 1'b0;
                            state_n    = ST_DWELL;
                            timer_load = 1'b1;
                        end
                    end else if (!dir_q && freq_num_i == lo_q) begin
                        dir_n      = 1'b1;
                        state_n    = ST_DWELL;
                        timer_load = 1'b1;
                    end else begin
                        state_n    = ST_DWELL;
                        timer_load = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase

            // Seek decisions run straight out of SETTLE so seek pulses stay 3 cycles apart.
            if (seek_eval) begin
                if (freq_num_i == lo_q) begin
                    dir_n      = 1'b1;
                    seek_n     = 1'b0;
                    state_n    = ST_DWELL;
                    timer_load = 1'b1;
                end else begin
                    dir_n   = (freq_num_i < lo_q);
                    seek_n  = 1'b1;
                    state_n = ST_STEP;
                    up_n    = dir_n;
                    down_n  = ~dir_n;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b1;
            seek_q       <= 1'b0;
            mode_q       <= 1'b0;
            lo_q         <= '0;
            hi_q         <= '0;
            prev_q       <= '0;
            dwell_q      <= '0;
            settle_q     <= '0;
            step_up_o    <= 1'b0;
            step_down_o  <= 1'b0;
            sweep_busy_o <= 1'b0;
            sweep_dir_o  <= 1'b1;
            sweep_err_o  <= 1'b0;
        end else begin
            state_q      <= state_n;
            dir_q        <= dir_n;
            seek_q       <= seek_n;
            mode_q       <= mode_n;
            lo_q         <= lo_n;
            hi_q         <= hi_n;
            prev_q       <= prev_n;
            dwell_q      <= dwell_n;
            settle_q     <= settle_n;
            step_up_o    <= up_n;
            step_down_o  <= down_n;
            sweep_busy_o <= (state_n != ST_IDLE);
            sweep_dir_o  <= dir_n;
            sweep_err_o  <= err_n;
        end
    end

endmodule

// File: doc/freq_sweep_ctrl.md
# freq_sweep_ctrl

Frequency sweep scheduler sitting between the debounced key triggers and `freq_sel`. It owns the `freq_sel` step inputs. It forwards manual up/down triggers when idle, and autonomously sweeps the frequency index between a low and a high bound with a programmable dwell per step. It reads `freq_num` back from `freq_sel` to track position and detect stalls.

## Interface
- `IDX_W`, 7: width of frequency index (matches `freq_num`).
- `DWELL_W`, 32: width of dwell count in `clk_i` cycles.
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  reset. One clock; reset is synchronous and active-low.
- `freq_up_trigger_i`  in  1  manual up pulse (debounced, edge-detected).
- `freq_down_trigger_i`  in  1  manual down pulse.
- `sweep_start_i`  in  1  pulse: latch bounds/dwell/mode, begin sweep.
- `sweep_stop_i`  in  1  pulse: abort sweep.
- `sweep_lo_i`  in  IDX_W  lower index bound.
- `sweep_hi_i`  in  IDX_W  upper index bound.
- `dwell_i`  in  DWELL_W  cycles spent at each index; 0 treated as 1.
- `sweep_mode_i`  in  1  0 = single pass lo→hi, 1 = ping-pong.
- `freq_num_i`  in  IDX_W  current index fed back from `freq_sel`.
- `step_up_o`  out  1  one-cycle step pulse to `freq_sel` up input.
- `step_down_o`  out  1  one-cycle step pulse to `freq_sel` down input.
- `sweep_busy_o`  out  1  high while not IDLE.
- `sweep_dir_o`  out  1  current sweep direction, 1 = up.
- `sweep_err_o`  out  1  one-cycle pulse on stall abort.

## Operation
- States: IDLE, SEEK, DWELL, STEP, SETTLE.
- Priority at each edge: reset > manual trigger > stop > start > FSM.
- Manual trigger, exactly one of up/down: forwarded on the matching `step_*_o` the next cycle. Any active sweep is aborted to IDLE, and no sweep pulse is issued that cycle. Both manual triggers together: ignored entirely, with no pulse and no abort.
- `sweep_stop_i`: go to IDLE, no pulse.
- `sweep_start_i` with lo ≤ hi: latch lo, hi, max(dwell,1) and mode, then enter SEEK. This applies from any state, so a restart while busy re-latches. With lo > hi the start is ignored and the FSM stays in its current state.
- SEEK:
  - If `freq_num_i` equals lo, set dir = up and enter DWELL.
  - Otherwise step toward lo (STEP then SETTLE), with no dwell between seek steps.
- DWELL: count the latched dwell cycles, then go to STEP.
- STEP: assert `step_up_o` or `step_down_o` per dir for exactly one cycle, and record `freq_num_i` as prev.
- SETTLE: lasts 2 cycles. At its end:
  - `freq_num_i` == prev means a stall (freq_sel saturated). Pulse `sweep_err_o` and go to IDLE.
  - In SEEK context, return to SEEK.
  - dir up and `freq_num_i` == hi: mode 0 goes to IDLE; mode 1 sets dir = down and enters DWELL.
  - dir down and `freq_num_i` == lo: set dir = up and enter DWELL. This case occurs only in mode 1.
  - Otherwise enter DWELL.
- Index comparisons are unsigned IDX_W. The dwell counter is DWELL_W and never wraps, because it reloads on every DWELL entry.

## Timing
- All outputs are registered.
- Reset values: `step_up_o`=0, `step_down_o`=0, `sweep_busy_o`=0, `sweep_dir_o`=1, `sweep_err_o`=0. State resets to IDLE and all latched registers to 0.
- Manual trigger to step pulse: 1 cycle latency.
- `sweep_start_i` to `sweep_busy_o` high: 1 cycle.
- Seek pulse spacing: 3 cycles (STEP + 2 SETTLE).
- Sweep pulse spacing: max(dwell,1) + 3 cycles.
- Reset asserted mid-sweep: outputs return to reset values on the next edge, and no further pulses are issued.
- `freq_sel` must reflect a step within 2 cycles.

## Structure
- Shared package `freq_ctrl_pkg` holds the following, reused by `freq_sel_top`-level integration:
  - state enum `sweep_state_t`;
  - `SETTLE_CYCLES` = 2;
  - `IDX_W` default.
- Sub-module `dwell_timer`: load/count-down/done, DWELL_W wide.

## Test plan
The bench includes a `freq_sel` model that updates its index 1 cycle after a pulse and saturates at 0..99.

- Idle, single `freq_up_trigger_i` at index 10 → `step_up_o` one cycle later, index 11, `sweep_busy_o`=0.
- Start at index 20, lo=5, hi=8, dwell=4, mode 0 → 15 down pulses spaced 3 cycles, then 3 up pulses spaced 7 cycles, ending at 8 with `sweep_busy_o`=0.
- Mode 1, lo=3, hi=5, dwell=0 → up pulses from 3 to 5, then down pulses to 3, then repeating; dir toggles at 5 and 3; pulse spacing 4 cycles.
- Manual down during DWELL of a sweep → one `step_down_o`, FSM to IDLE, no further sweep pulses. Both manual triggers in the same cycle → no pulse and the sweep continues.
- hi=120 with the model saturating at 99 → after the pulse at 99, `sweep_err_o` pulses once and `sweep_busy_o` falls. Start with lo=9, hi=4 → ignored, busy stays 0.
- `rst_n_i` low during SETTLE → all outputs at reset values the next cycle, no pulses afterward.
